// File: rtl/echo_capture.sv
// echo_capture: ultrasonic echo time-of-flight receiver with ring-down blanking.
// Optional second-echo capture into tof2 is compiled in with ECHO_SECOND_EN.
module echo_capture #(
    parameter int CNT_W       = 20,
    parameter int BLANK_CYC   = 2400,
    parameter int TIMEOUT_CYC = 720000,
    parameter int FILT_LEN    = 4
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             burst_finish,
    input  logic             echo_in,
    output logic             busy,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic [CNT_W-1:0] tof2,
    output logic             tof2_valid,
    output logic             timeout
);

    localparam int RW = $clog2(FILT_LEN + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BLANK   = 2'd1;
    localparam logic [1:0] S_LISTEN  = 2'd2;
`ifdef ECHO_SECOND_EN
    localparam logic [1:0] S_LISTEN2 = 2'd3;
`endif

    localparam logic [CNT_W-1:0] BLANK_END   = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0]    RUN_LAST    = RW'(FILT_LEN - 1);

    logic [1:0]       sync;
    logic             echo_s;
    logic             bf_d;
    logic             start;
    logic [1:0]       state;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] cap_time;
    logic [RW-1:0]    run;
    logic             run_done;
    logic             at_timeout;

    assign echo_s     = sync[1];
    assign start      = burst_finish & ~bf_d;
    assign busy       = (state != S_IDLE);
    assign run_done   = echo_s && (run == RUN_LAST);
    assign at_timeout = (tcnt == TIMEOUT_END);
    // A one-sample filter qualifies on the very sample that starts the run.
    assign cap_time   = (run == '0) ? tcnt : cand;

`ifdef ECHO_SECOND_EN
    logic quiet;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            sync       <= '0;
            bf_d       <= 1'b0;
            state      <= S_IDLE;
            tcnt       <= '0;
            cand       <= '0;
            run        <= '0;
            quiet      <= 1'b0;
            tof        <= '0;
            tof_valid  <= 1'b0;
            tof2       <= '0;
            tof2_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync       <= {sync[0], echo_in};
            bf_d       <= burst_finish;
            tof_valid  <= 1'b0;
            tof2_valid <= 1'b0;
            timeout    <= 1'b0;
            if (busy) tcnt <= tcnt + CNT_W'(1);
            if (start) begin
                state <= S_BLANK;
                tcnt  <= '0;
                run   <= '0;
                quiet <= 1'b0;
            end else begin
                unique case (state)
                    S_BLANK: begin
                        if (tcnt == BLANK_END) state <= S_LISTEN;
                    end
                    S_LISTEN: begin
                        run <= echo_s ? run + RW'(1) : '0;
                        if (echo_s && run == '0) cand <= tcnt;
                        if (run_done) begin
                            tof       <= cap_time;
                            tof_valid <= 1'b1;
                            run       <= '0;
                            quiet     <= 1'b0;
                            state     <= S_LISTEN2;
                        end else if (at_timeout) begin
                            timeout <= 1'b1;
                            run     <= '0;
                            state   <= S_IDLE;
                        end
                    end
                    S_LISTEN2: begin
                        // Wait for the first echo to die away before arming again.
                        if (!quiet) begin
                            if (echo_s) begin
                                run <= '0;
                            end else if (run == RUN_LAST) begin
                                quiet <= 1'b1;
                                run   <= '0;
                            end else begin
                                run <= run + RW'(1);
                            end
                        end else begin
                            run <= echo_s ? run + RW'(1) : '0;
                            if (echo_s && run == '0) cand <= tcnt;
                        end
                        if (quiet && run_done) begin
                            tof2       <= cap_time;
                            tof2_valid <= 1'b1;
                            run        <= '0;
                            state      <= S_IDLE;
                        end else if (at_timeout) begin
                            timeout <= 1'b1;
                            run     <= '0;
                            state   <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    assign tof2       = '0;
    assign tof2_valid = 1'b0;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            bf_d      <= 1'b0;
            state     <= S_IDLE;
            tcnt      <= '0;
            cand      <= '0;
            run       <= '0;
            tof       <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            sync      <= {sync[0], echo_in};
            bf_d      <= burst_finish;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
            if (busy) tcnt <= tcnt + CNT_W'(1);
            if (start) begin
                state <= S_BLANK;
                tcnt  <= '0;
                run   <= '0;
            end else begin
                unique case (state)
                    S_BLANK: begin
                        if (tcnt == BLANK_END) state <= S_LISTEN;
                    end
                    S_LISTEN: begin
                        run <= echo_s ? run + RW'(1) : '0;
                        if (echo_s && run == '0) cand <= tcnt;
                        // Qualification takes priority over a coincident timeout.
                        if (run_done) begin
                            tof       <= cap_time;
                            tof_valid <= 1'b1;
                            run       <= '0;
                            state     <= S_IDLE;
                        end else if (at_timeout) begin
                            timeout <= 1'b1;
                            run     <= '0;
                            state   <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: directed echo scenarios for echo_capture, checked every
// cycle against a window-search model of the capture rules.
module tb_echo_capture;

    localparam int CW   = 20;
    localparam int BL   = 100;
    localparam int TO   = 1000;
    localparam int FL   = 4;
    localparam int TMAX = 1200;

    localparam int M_OFF  = 0;
    localparam int M_IDLE = 1;
    localparam int M_PRE  = 2;
    localparam int M_MEAS = 3;

    logic          gclk = 1'b0;
    logic          rst = 1'b1;
    logic          burst_finish = 1'b0;
    logic          echo_in = 1'b0;
    logic          busy;
    logic          tof_valid;
    logic          tof2_valid;
    logic          timeout;
    logic [CW-1:0] tof;
    logic [CW-1:0] tof2;

    echo_capture #(
        .CNT_W(CW),
        .BLANK_CYC(BL),
        .TIMEOUT_CYC(TO),
        .FILT_LEN(FL)
    ) dut (
        .gclk(gclk),
        .rst(rst),
        .burst_finish(burst_finish),
        .echo_in(echo_in),
        .busy(busy),
        .tof(tof),
        .tof_valid(tof_valid),
        .tof2(tof2),
        .tof2_valid(tof2_valid),
        .timeout(timeout)
    );

    always #5 gclk = ~gclk;

    int errors = 0;
    int checks = 0;
    int mode = M_IDLE;
    int e_next = 0;
    bit lvl [0:TMAX];
    int q1 = -1, t1 = 0, q2 = -1, t2 = 0;
    int to_edge = -1, end_edge = 0;
    int prev_tof = 0, prev_tof2 = 0;
    int seen_valid = -1, seen_valid2 = -1, seen_to = -1, n_valid = 0;
    int e_busy, e_v, e_v2, e_to, e_t, e_t2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, e_next);
        end
    endtask

    // Synchronized echo as seen at edge e: the pin level two edges earlier.
    function automatic bit es(input int e);
        if (e < 2 || e - 2 > TMAX) return 1'b0;
        return lvl[e-2];
    endfunction

    // Earliest edge m >= from where FL samples all equal v, finishing by TO.
    function automatic int find_run(input int from, input bit v);
        for (int m = from; m + FL - 1 <= TO; m++) begin
            bit ok = 1'b1;
            for (int j = 0; j < FL; j++)
                if (es(m + j) != v) ok = 1'b0;
            if (ok) return m;
        end
        return -1;
    endfunction

    always @(posedge gclk) begin
        #2;
        if (mode != M_OFF) begin
            e_busy = 0; e_v = 0; e_v2 = 0; e_to = 0;
            e_t = prev_tof; e_t2 = prev_tof2;
            if (mode == M_PRE) begin
                e_busy = 1;
            end else if (mode == M_MEAS) begin
                e_busy = int'(e_next < end_edge);
                e_v    = int'(e_next == q1);
                e_v2   = int'(e_next == q2);
                e_to   = int'(e_next == to_edge);
                if (q1 >= 0 && e_next >= q1) e_t = t1;
                if (q2 >= 0 && e_next >= q2) e_t2 = t2;
                if (tof_valid) begin
                    seen_valid = e_next;
                    n_valid++;
                end
                if (tof2_valid) seen_valid2 = e_next;
                if (timeout) seen_to = e_next;
            end
            chk("busy", int'(busy), e_busy);
            chk("tof_valid", int'(tof_valid), e_v);
            chk("tof2_valid", int'(tof2_valid), e_v2);
            chk("timeout", int'(timeout), e_to);
            chk("tof", int'(tof), e_t);
            chk("tof2", int'(tof2), e_t2);
        end
    end

    task automatic meas(input int pre, input int n1, input int l1,
                        input int n2, input int l2);
        int m1, m2, p;
        for (int i = 0; i <= TMAX; i++) lvl[i] = 1'b0;
        for (int i = 0; i < l1; i++) lvl[n1+i] = 1'b1;
        for (int i = 0; i < l2; i++) lvl[n2+i] = 1'b1;
        q1 = -1; q2 = -1; t1 = 0; t2 = 0; to_edge = -1;
        m1 = find_run(BL + 1, 1'b1);
        if (m1 < 0) begin
            to_edge = TO;
            end_edge = TO;
        end else begin
            q1 = m1 + FL - 1;
            t1 = m1 - 1;
            end_edge = q1;
`ifdef ECHO_SECOND_EN
            p = find_run(q1 + 1, 1'b0);
            m2 = (p < 0) ? -1 : find_run(p + FL, 1'b1);
            if (m2 < 0) begin
                to_edge = TO;
                end_edge = TO;
            end else begin
                q2 = m2 + FL - 1;
                t2 = m2 - 1;
                end_edge = q2;
            end
`else
            p = 0;
            m2 = p;
`endif
        end
        seen_valid = -1; seen_valid2 = -1; seen_to = -1; n_valid = 0;
        if (pre > 0) begin
            @(negedge gclk);
            burst_finish = 1'b1; echo_in = 1'b0; mode = M_PRE; e_next = 0;
            for (int e = 0; e < pre - 1; e++) begin
                @(negedge gclk);
                burst_finish = 1'b0;
                e_next = e + 1;
            end
        end
        @(negedge gclk);
        burst_finish = 1'b1; echo_in = lvl[0]; e_next = 0; mode = M_MEAS;
        for (int e = 0; e <= end_edge + 4; e++) begin
            @(negedge gclk);
            burst_finish = 1'b0;
            echo_in = lvl[e+1];
            e_next = e + 1;
        end
        echo_in = 1'b0;
        if (q1 >= 0) prev_tof = t1;
        if (q2 >= 0) prev_tof2 = t2;
        mode = M_IDLE;
    endtask

    initial begin
        repeat (3) @(negedge gclk);
        rst = 1'b0;
        repeat (2) @(negedge gclk);

        meas(0, 299, 10, 0, 0);
        chk("model_q1_basic", q1, 304);
        chk("tof_basic", int'(tof), 300);
        chk("valid_edge_basic", seen_valid, 304);

        meas(0, 20, 41, 0, 0);
        chk("blank_timeout_edge", seen_to, 1000);
        chk("blank_nvalid", n_valid, 0);
        chk("blank_tof_held", int'(tof), 300);

        meas(0, 200, 3, 400, 6);
        chk("glitch_tof", int'(tof), 401);
        chk("glitch_nvalid", n_valid, 1);
        chk("glitch_valid_edge", seen_valid, 405);

        meas(50, 299, 10, 0, 0);
        chk("restart_tof", int'(tof), 300);
        chk("restart_nvalid", n_valid, 1);

        meas(0, 299, 10, 599, 10);
        chk("second_tof", int'(tof), 300);
`ifdef ECHO_SECOND_EN
        chk("second_tof2", int'(tof2), 600);
        chk("second_valid2_edge", seen_valid2, 604);
`else
        chk("second_tof2_tied", int'(tof2), 0);
        chk("second_valid2_none", seen_valid2, -1);
`endif

        for (int i = 0; i <= TMAX; i++) lvl[i] = 1'b0;
        for (int i = 299; i < 309; i++) lvl[i] = 1'b1;
        @(negedge gclk);
        burst_finish = 1'b1; mode = M_PRE; e_next = 0;
        for (int e = 0; e < 149; e++) begin
            @(negedge gclk);
            burst_finish = 1'b0;
            echo_in = lvl[e+1];
            e_next = e + 1;
        end
        @(negedge gclk);
        rst = 1'b1; prev_tof = 0; prev_tof2 = 0; mode = M_IDLE;
        @(negedge gclk);
        rst = 1'b0;
        for (int e = 0; e < 1100; e++) begin
            @(negedge gclk);
            echo_in = lvl[e+1];
        end
        echo_in = 1'b0;
        @(negedge gclk);
        chk("reset_tof", int'(tof), 0);
        chk("reset_busy", int'(busy), 0);

        mode = M_OFF;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/echo_capture.md
# echo_capture

Ultrasonic echo receiver and time-of-flight counter, the receive-side counterpart of the burst generator. It arms on the rising edge of `burst_finish`, blanks transducer ring-down, then timestamps the first glitch-filtered echo on the comparator input. It reports the flight time in `gclk` cycles, or a timeout if no echo arrives, to the main control logic.

## Interface
Parameters:
- `CNT_W`, 20: width of the time counter and of `tof`/`tof2`.
- `BLANK_CYC`, 2400: ring-down blanking length in cycles (100 us at 24 MHz).
- `TIMEOUT_CYC`, 720000: listen window end in cycles (30 ms). Legal range: `BLANK_CYC + FILT_LEN < TIMEOUT_CYC <= 2^CNT_W`.
- `FILT_LEN`, 4: number of consecutive synchronized high samples required for a valid echo. Must be at least 1.

Ports:
- `gclk` in 1: system clock, 24 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `burst_finish` in 1: start trigger. Only its rising edge is used.
- `echo_in` in 1: asynchronous comparator output, active high.
- `busy` out 1: high in BLANK, LISTEN and LISTEN2.
- `tof` out CNT_W: first-echo flight time. Held until the next capture.
- `tof_valid` out 1: one-cycle pulse when `tof` updates.
- `tof2` out CNT_W: second-echo flight time (see Configuration).
- `tof2_valid` out 1: one-cycle pulse when `tof2` updates.
- `timeout` out 1: one-cycle pulse when the listen window ends without the expected echo.

## Operation
- `echo_in` passes through a 2-flop synchronizer to produce `echo_s`. Measured times include this 2-cycle latency; the block does not compensate for it.
- `start` is `burst_finish & ~burst_finish_d`, using one register on `burst_finish`.
- The time counter `tcnt` is cleared when `start` is accepted and increments on every edge while `busy` is high.
- States:
  - IDLE: on `start`, go to BLANK and set `tcnt` to 0.
  - BLANK: `echo_s` is ignored. At the edge where `tcnt == BLANK_CYC-1`, go to LISTEN.
  - LISTEN: a run counter counts consecutive `echo_s` high samples and clears on any low sample. The first high sample of a run latches `cand = tcnt`. When the run count reaches `FILT_LEN`:
    - `tof` is loaded with `cand` and `tof_valid` pulses.
    - Next state is IDLE, or LISTEN2 when the second-echo feature is enabled.
  - LISTEN: at the edge where `tcnt == TIMEOUT_CYC-1` with no qualifying run, `timeout` pulses and the FSM returns to IDLE. `tof` is not changed.
  - LISTEN2: only exists when the second-echo feature is compiled in; see Configuration.
- If `echo_s` is already high on the first LISTEN edge, that sample starts a run, giving `cand = BLANK_CYC`.
- Qualification and timeout on the same edge: qualification wins and `timeout` does not pulse.
- `start` while busy aborts the current measurement with no valid or timeout pulse, restarts BLANK with `tcnt` = 0, and clears the run counter.
- `rst` asserted mid-measurement clears everything immediately. No pulses follow release.

## Timing
- Reset values: `busy`, `tof_valid`, `tof2_valid` and `timeout` are 0; `tof` and `tof2` are 0; state is IDLE; synchronizer flops are 0.
- `tcnt` equals k after the k-th edge following the start edge E0.
- `echo_in` rising before edge E_n and held high gives `tof = n+1`, with `tof_valid` rising at edge E_(n+1+FILT_LEN).
- `busy` rises at E0 and falls on the edge that issues the final `tof_valid`, `tof2_valid` or `timeout`.
- A new `start` is accepted in IDLE on the edge immediately after `busy` falls.

## Configuration
- `ECHO_SECOND_EN` defined:
  - After the first capture the FSM enters LISTEN2.
  - LISTEN2 first requires `echo_s` low for `FILT_LEN` consecutive samples, then qualifies a second run using the same filter rule.
  - On qualification it loads `tof2` and pulses `tof2_valid`.
  - The timeout edge in LISTEN2 pulses `timeout` and leaves `tof2` unchanged.
- `ECHO_SECOND_EN` undefined:
  - No LISTEN2 state; the FSM returns to IDLE after the first capture.
  - `tof2` is tied to 0 and `tof2_valid` is tied to 0.

## Test plan
Bench parameters: `BLANK_CYC`=100, `TIMEOUT_CYC`=1000, `FILT_LEN`=4, `CNT_W`=20.
- Basic capture: start, then `echo_in` high from before E_299 for 10 cycles -> `tof`=300, `tof_valid` at E_304, `busy` low after E_304.
- Blanking: `echo_in` high over E_20..E_60, low after, no other echo -> no `tof_valid`; `timeout` at edge E_1000.
- Glitch filter: 3-cycle echo at E_200, then a 6-cycle echo from E_400 -> only one capture, `tof`=401.
- Restart: start, then a second `burst_finish` rising edge at E_50, then echo before E_299 relative to the new start -> single `tof_valid`, `tof`=300 relative to the new start.
- Reset mid-measurement: `rst` pulsed at E_150 -> all outputs 0 and IDLE, no further pulses, `tof` remains 0.
- Second echo (`ECHO_SECOND_EN`): echoes at E_299 and E_599, each 10 cycles -> `tof`=300 and `tof2`=600. Without the macro -> `tof2`=0 and never pulses.
